jtframe_pocket_vidpack: RTL and testbench

Upstream neighbour of the Pocket scaler video bus. It converts the core's pixel stream into the scaler-side signals: scal_vid, scal_de, scal_skip, scal_hs and scal_vs. The inputs are pixel-enable-qualified RGB, blanking and sync. Outputs are single-clock sync pulses, a registered data-enable, an end-of-line command word, skip marking, and frame/line counters for the test harness. The 24-bit to 12-bit DDR split is done by an external DDIO cell fed from vid_rgb.

---
 rtl/jtframe_pocket_pkg.sv | 24 ++
 rtl/jtframe_pocket_syncpulse.sv | 23 ++
 rtl/jtframe_pocket_vidpack.sv | 135 +++++++++++++
 tb/tb_jtframe_pocket_vidpack.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_pocket_pkg.sv
// Shared types and helpers for the Pocket scaler video packer.
// Holds the line state encoding and colour expansion.
package jtframe_pocket_pkg;

    localparam logic [2:0] EOL_CMD = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        EOL,
        HBLANK
    } state_t;

    // c holds cw valid bits right-aligned; MSBs repeat into the LSBs
    function automatic logic [7:0] colour_expand(input logic [7:0] c, input int cw);
        logic [7:0] o;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            o[3'(7 - i)] = c[3'(cw - 1 - (i % cw))];
        end
        return o;
    endfunction

endpackage

// File: rtl/jtframe_pocket_syncpulse.sv
// Rising-edge detector sampled on the pixel enable.
// The edge register loads the live level in reset.
module jtframe_pocket_syncpulse (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic sig,
    output logic rise
);

    logic last;

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= sig;
        end else if (cen) begin
            last <= sig;
        end
    end

    assign rise = cen & sig & ~last;

endmodule

// File: rtl/jtframe_pocket_vidpack.sv
// Packs the core pixel stream into Pocket scaler video signals.
// Outputs update only on pixel-enable ticks; hs/vs are 1-clk pulses.
module jtframe_pocket_vidpack
    import jtframe_pocket_pkg::*;
#(
    parameter logic [2:0] SLOT   = 3'd0,
    parameter logic [3:0] HS_DLY = 4'd3,
    parameter int         CW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic [CW-1:0] red,
    input  logic [CW-1:0] green,
    input  logic [CW-1:0] blue,
    input  logic          lhbl,
    input  logic          lvbl,
    input  logic          hs,
    input  logic          vs,
    output logic [23:0]   vid_rgb,
    output logic          vid_de,
    output logic          vid_skip,
    output logic          vid_hs,
    output logic          vid_vs,
    output logic [31:0]   frame_cnt,
    output logic [11:0]   line_cnt,
    output logic          sync_err
);

    state_t      st;
    state_t      st_nx;
    logic        hs_rise;
    logic        vs_rise;
    logic [3:0]  dly;
    logic [23:0] rgb_nx;
    logic        de_nx;
    logic        eol_nx;

    jtframe_pocket_syncpulse u_hs (
        .clk  (clk),
        .rst  (rst),
        .cen  (pxl_cen),
        .sig  (hs),
        .rise (hs_rise)
    );

    jtframe_pocket_syncpulse u_vs (
        .clk  (clk),
        .rst  (rst),
        .cen  (pxl_cen),
        .sig  (vs),
        .rise (vs_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
        end else if (pxl_cen) begin
            st <= st_nx;
        end
    end

    always_comb begin
        st_nx = st;
        if (!lvbl) begin
            st_nx = IDLE;
        end else if (lhbl) begin
            st_nx = ACTIVE;
        end else begin
            unique case (st)
                ACTIVE:  st_nx = EOL;
                EOL:     st_nx = HBLANK;
                default: st_nx = st;
            endcase
        end
    end

    // EOL is only reachable from ACTIVE, so one command word per line
    always_comb begin
        rgb_nx = '0;
        de_nx  = 1'b0;
        eol_nx = 1'b0;
        if (lhbl && lvbl) begin
            de_nx  = 1'b1;
            rgb_nx = {colour_expand(8'(red), CW),
                      colour_expand(8'(green), CW),
                      colour_expand(8'(blue), CW)};
        end else if (st_nx == EOL) begin
            eol_nx = 1'b1;
            rgb_nx = {18'd0, SLOT, EOL_CMD};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vid_rgb   <= '0;
            vid_de    <= 1'b0;
            vid_skip  <= 1'b1;
            vid_hs    <= 1'b0;
            vid_vs    <= 1'b0;
            frame_cnt <= '0;
            line_cnt  <= '0;
            sync_err  <= 1'b0;
            dly       <= '0;
        end else begin
            vid_skip <= ~pxl_cen;
            vid_hs   <= 1'b0;
            vid_vs   <= 1'b0;
            if (pxl_cen) begin
                vid_rgb <= rgb_nx;
                vid_de  <= de_nx;
                if (dly != 4'd0) begin
                    dly <= dly - 4'd1;
                end
                if (vs_rise) begin
                    vid_vs    <= 1'b1;
                    frame_cnt <= frame_cnt + 32'd1;
                    line_cnt  <= '0;
                    dly       <= HS_DLY;
                end else if (eol_nx && line_cnt != 12'hFFF) begin
                    line_cnt <= line_cnt + 12'd1;
                end
                // hs too close to vs is dropped and flagged
                if (hs_rise) begin
                    if (vs_rise || dly != 4'd0) begin
                        sync_err <= 1'b1;
                    end else begin
                        vid_hs <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_jtframe_pocket_vidpack.sv
// Self-checking bench for jtframe_pocket_vidpack.
// Reference model tracks the expected outputs per clk.
module tb_jtframe_pocket_vidpack;

    localparam int         CW     = 4;
    localparam logic [2:0] SLOT   = 3'd0;
    localparam int         HS_DLY = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pxl_cen;
    logic [3:0]  red, green, blue;
    logic        lhbl, lvbl, hs, vs;
    logic [23:0] vid_rgb;
    logic        vid_de, vid_skip, vid_hs, vid_vs;
    logic [31:0] frame_cnt;
    logic [11:0] line_cnt;
    logic        sync_err;

    int errors = 0;
    int checks = 0;

    logic [23:0] e_rgb;
    logic        e_de, e_skip, e_hs, e_vs, e_err;
    logic [31:0] e_frame;
    int          e_line;
    logic        p_hs, p_vs, p_act;
    int          since_vs;

    logic [72:0] got_v;
    logic [72:0] exp_v;

    assign got_v = {vid_rgb, vid_de, vid_skip, vid_hs, vid_vs,
                    frame_cnt, line_cnt, sync_err};
    assign exp_v = {e_rgb, e_de, e_skip, e_hs, e_vs,
                    e_frame, 12'(e_line), e_err};

    jtframe_pocket_vidpack #(
        .SLOT   (SLOT),
        .HS_DLY (4'(HS_DLY)),
        .CW     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pxl_cen   (pxl_cen),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .lhbl      (lhbl),
        .lvbl      (lvbl),
        .hs        (hs),
        .vs        (vs),
        .vid_rgb   (vid_rgb),
        .vid_de    (vid_de),
        .vid_skip  (vid_skip),
        .vid_hs    (vid_hs),
        .vid_vs    (vid_vs),
        .frame_cnt (frame_cnt),
        .line_cnt  (line_cnt),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: run did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] x8(input logic [3:0] c);
        int v;
        int b;
        v = int'(c);
        b = CW;
        while (b < 8) begin
            v = (v << CW) | int'(c);
            b += CW;
        end
        return 8'(v >> (b - 8));
    endfunction

    task automatic m_reset();
        e_rgb    = '0;
        e_de     = 1'b0;
        e_skip   = 1'b1;
        e_hs     = 1'b0;
        e_vs     = 1'b0;
        e_err    = 1'b0;
        e_frame  = '0;
        e_line   = 0;
        p_hs     = hs;
        p_vs     = vs;
        p_act    = 1'b0;
        since_vs = 1000;
    endtask

    task automatic model_step();
        logic hr, vr, eol;
        e_skip = !pxl_cen;
        e_hs   = 1'b0;
        e_vs   = 1'b0;
        if (pxl_cen) begin
            since_vs++;
            hr  = hs && !p_hs;
            vr  = vs && !p_vs;
            eol = lvbl && !lhbl && p_act;
            if (lhbl && lvbl) begin
                e_de  = 1'b1;
                e_rgb = {x8(red), x8(green), x8(blue)};
            end else begin
                e_de  = 1'b0;
                e_rgb = eol ? {18'd0, SLOT, 3'b001} : 24'd0;
            end
            if (vr) begin
                e_vs     = 1'b1;
                e_frame  = e_frame + 32'd1;
                e_line   = 0;
                since_vs = 0;
            end else if (eol && e_line < 4095) begin
                e_line++;
            end
            if (hr) begin
                if (vr || since_vs <= HS_DLY) e_err = 1'b1;
                else e_hs = 1'b1;
            end
            p_hs  = hs;
            p_vs  = vs;
            p_act = lhbl && lvbl;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) m_reset();
        else model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; hs = 1'b1; vs = 1'b1;
        lhbl = 1'b1; lvbl = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pxl_cen = (i % 2 == 0);
            tick();
            checks++;
            if ({vid_rgb, vid_de, vid_hs, vid_vs, frame_cnt, line_cnt, sync_err} !== '0
                || vid_skip !== 1'b1) begin
                errors++;
                $display("FAIL reset_state got=%h skip=%b req=0 skip=1",
                         got_v, vid_skip);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pxl_cen = (i % 2 == 0);
            tick();
            checks++;
            if (vid_hs !== 1'b0 || vid_vs !== 1'b0) begin
                errors++;
                $display("FAIL no_spurious_sync hs=%b vs=%b req=0", vid_hs, vid_vs);
            end
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL post_reset got=%h req=%h", got_v, exp_v);
            end
        end
    endtask

    task automatic test_colour();
        int n_ok;
        pxl_cen = 1'b1; hs = 1'b0; vs = 1'b0;
        lvbl = 1'b1; lhbl = 1'b0;
        red = 4'hA; green = 4'h5; blue = 4'hF;
        for (int i = 0; i < 2; i++) tick();
        lhbl = 1'b1;
        n_ok = 0;
        for (int i = 0; i < 320; i++) begin
            tick();
            if (vid_de === 1'b1 && vid_rgb === 24'hAA55FF) n_ok++;
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL colour_vec got=%h req=%h", got_v, exp_v);
            end
        end
        checks++;
        if (n_ok !== 320) begin
            errors++;
            $display("FAIL colour_pixels got=%0d req=320", n_ok);
        end
        lhbl = 1'b0;
        tick();
        checks++;
        if (vid_rgb !== 24'h000001 || vid_de !== 1'b0) begin
            errors++;
            $display("FAIL eol_word got=%h de=%b req=000001 de=0", vid_rgb, vid_de);
        end
        tick();
        checks++;
        if (vid_rgb !== 24'h0 || line_cnt !== 12'd1) begin
            errors++;
            $display("FAIL single_eol rgb=%h line=%0d req=0 line=1", vid_rgb, line_cnt);
        end
    endtask

    task automatic test_skip();
        int n_skip, n_hs;
        n_skip = 0;
        n_hs   = 0;
        for (int l = 0; l < 3; l++) begin
            red   = 4'($urandom);
            green = 4'($urandom);
            blue  = 4'($urandom);
            for (int t = 0; t < 12; t++) begin
                lhbl = (t < 8);
                hs   = (t == 9 || t == 10);
                for (int c = 0; c < 4; c++) begin
                    pxl_cen = (c == 0);
                    tick();
                    if (vid_skip === 1'b1) n_skip++;
                    if (vid_hs === 1'b1) n_hs++;
                    checks++;
                    if (got_v !== exp_v) begin
                        errors++;
                        $display("FAIL skip_vec got=%h req=%h", got_v, exp_v);
                    end
                end
            end
        end
        checks++;
        if (n_skip !== 108) begin
            errors++;
            $display("FAIL skip_count got=%0d req=108", n_skip);
        end
        checks++;
        if (n_hs !== 3) begin
            errors++;
            $display("FAIL hs_per_line got=%0d req=3", n_hs);
        end
    endtask

    task automatic test_frame();
        pxl_cen = 1'b1;
        for (int l = 0; l < 224; l++) begin
            for (int t = 0; t < 6; t++) begin
                lhbl = (t < 4);
                hs   = (t == 5);
                tick();
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL frame_vec got=%h req=%h", got_v, exp_v);
                end
            end
        end
        checks++;
        if (line_cnt !== 12'd228 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL lines_before_vs line=%0d err=%b req=228 err=0",
                     line_cnt, sync_err);
        end
        lvbl = 1'b0; lhbl = 1'b0; hs = 1'b0; vs = 1'b1;
        tick();
        checks++;
        if (vid_vs !== 1'b1 || frame_cnt !== 32'd1 || line_cnt !== 12'd0) begin
            errors++;
            $display("FAIL vs_pulse vs=%b frame=%0d line=%0d req=1,1,0",
                     vid_vs, frame_cnt, line_cnt);
        end
        tick();
        checks++;
        if (vid_vs !== 1'b0) begin
            errors++;
            $display("FAIL vs_width got=%b req=0", vid_vs);
        end
        hs = 1'b1;
        tick();
        checks++;
        if (vid_hs !== 1'b0 || sync_err !== 1'b1) begin
            errors++;
            $display("FAIL hs_suppress hs=%b err=%b req=0,1", vid_hs, sync_err);
        end
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL frame_end got=%h req=%h", got_v, exp_v);
        end
    endtask

    task automatic test_blank_mid();
        vs = 1'b0; hs = 1'b0;
        lvbl = 1'b1; lhbl = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        lvbl = 1'b0;
        tick();
        checks++;
        if (vid_de !== 1'b0 || vid_rgb !== 24'h0) begin
            errors++;
            $display("FAIL blank_de de=%b rgb=%h req=0,0", vid_de, vid_rgb);
        end
        lhbl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) lvbl = 1'b1;
            tick();
            checks++;
            if (vid_rgb !== 24'h0 || line_cnt !== 12'd0) begin
                errors++;
                $display("FAIL no_eol rgb=%h line=%0d req=0,0", vid_rgb, line_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        force dut.frame_cnt = 32'hFFFFFFFF;
        e_frame = 32'hFFFFFFFF;
        pxl_cen = 1'b0;
        tick();
        release dut.frame_cnt;
        pxl_cen = 1'b1;
        vs = 1'b1;
        tick();
        checks++;
        if (frame_cnt !== 32'd0 || vid_vs !== 1'b1) begin
            errors++;
            $display("FAIL frame_wrap got=%h vs=%b req=0 vs=1", frame_cnt, vid_vs);
        end
        lvbl = 1'b1;
        for (int l = 0; l < 5000; l++) begin
            lhbl = 1'b1;
            tick();
            lhbl = 1'b0;
            tick();
        end
        checks++;
        if (line_cnt !== 12'd4095) begin
            errors++;
            $display("FAIL line_sat got=%0d req=4095", line_cnt);
        end
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL wrap_vec got=%h req=%h", got_v, exp_v);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            rst     = (i >= 2000 && i < 2002);
            pxl_cen = ($urandom % 3) != 0;
            lhbl    = ($urandom % 8) != 0;
            lvbl    = ($urandom % 32) != 0;
            hs      = ($urandom % 6) == 0;
            vs      = ($urandom % 40) == 0;
            red     = 4'($urandom);
            green   = 4'($urandom);
            blue    = 4'($urandom);
            tick();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_vec i=%0d got=%h req=%h", i, got_v, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0;
        red = '0; green = '0; blue = '0;
        lhbl = 1'b1; lvbl = 1'b0; hs = 1'b1; vs = 1'b1;
        m_reset();
        test_reset();
        test_colour();
        test_skip();
        test_frame();
        test_blank_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
